serial_operand_serializer: RTL and testbench
============================================

// Module: serial_operand_serializer
// PURPOSE
//  Parallel-to-serial front end for the serial adder with valid.
//  - Accepts a pair of W-bit operands over a valid/ready handshake.
//  - Shifts them out LSB-first, one bit pair per cycle, on a/b with vld/last.
//  - Output port names and meanings match the serial adder inputs 1:1.
//  - Supports a per-word bit length, downstream stall (out_en), back-to-back words.
// PARAMETERS
//  W     8   operand width in bits (>=2)
//  LW    $clog2(W+1)   width of in_len / bit counter (localparam, derived)
// PORTS
//  clk     in   1   clock
//  rst     in   1   synchronous, active-high reset
//  in_vld  in   1   operand pair valid
//  in_rdy  out  1   block can accept operands this cycle
//  in_a    in   W   operand A
//  in_b    in   W   operand B
//  in_len  in   LW  bits to send (1..W); 0 or >W means W
//  out_en  in   1   downstream allows a bit this cycle; 0 = stall
//  vld     out  1   a/b carry a valid bit pair
//  a       out  1   current bit of A (LSB first)
//  b       out  1   current bit of B (LSB first)
//  last    out  1   current bit pair is the final one of the word (qualified by vld)
//  busy    out  1   word in flight (state SHIFT)
// BEHAVIOUR
//  - Reset state: IDLE, counter 0, shift regs 0.
//    Outputs after reset: in_rdy=1, vld=0, a=0, b=0, last=0, busy=0.
//  - FSM states IDLE and SHIFT.
//    - IDLE -> SHIFT on in_vld&&in_rdy.
//    - SHIFT -> IDLE on vld&&last with no new accept.
//    - SHIFT -> SHIFT on vld&&last with a new accept.
//  - Accept: in_vld&&in_rdy at edge N loads sh_a=in_a, sh_b=in_b, cnt=len_eff.
//    - The first bit appears at cycle N+1 (one-cycle latency).
//  - Outputs are combinational from state/regs:
//    - vld = busy && out_en
//    - a = sh_a[0], b = sh_b[0]
//    - last = busy && (cnt==1)
//  - Shift only when vld: sh >>= 1 and cnt -= 1. If out_en=0, everything holds.
//    - The bit is re-presented and vld=0 (the adder ignores gaps).
//  - in_rdy = (state==IDLE) || (vld && last).
//    - Back-to-back words have no bubble between last of word k and bit 0 of word k+1.
//  - In SHIFT with in_rdy=0, in_vld is ignored; the operands must be held by the source.
//  - len_eff = (in_len==0 || in_len>W) ? W : in_len. Upper operand bits beyond len_eff are never sent.
//  - len_eff==1: the first bit cycle also has last=1.
//  - rst mid-word: next cycle is IDLE, vld=0, last=0. The partial word is dropped.
//    - The downstream adder is reset by the same rst.
//  - No arithmetic on data; cnt decrements only, never wraps (it is reloaded at accept).
// STRUCTURE
//  - serial_pkg: state_t enum {IDLE, SHIFT}; function len_eff(in_len, W).
//  - One sub-module, piso_shift_reg #(W): load/shift/hold, bit0 out.
//    - Instantiated for A and B.
//  - Top holds FSM, counter and handshake.
// TESTING
//  1. rst held 3 cycles
//     -> in_rdy=1, vld=0, last=0, busy=0 every cycle.
//  2. W=8, in_a=8'hA5, in_b=8'h3C, in_len=0, out_en=1
//     -> 8 vld cycles, a=1,0,1,0,0,1,0,1 and b=0,0,1,1,1,1,0,0.
//     -> last only on the 8th. Serial adder sum bits form 8'hE1.
//  3. in_len=3, in_a=8'hFF, in_b=8'h01
//     -> 3 vld cycles, last on the 3rd, in_rdy=1 on that cycle.
//     -> Next cycle vld=0 if no new word.
//  4. Two words with in_vld held: 8'h0F+8'h01 then 8'h80+8'h80
//     -> 16 consecutive vld cycles, no gap.
//     -> Adder yields 8'h10 then 8'h00.
//  5. out_en toggled 1,0,0,1,... during a word
//     -> vld tracks out_en, a/b frozen while 0.
//     -> Still exactly 8 vld bits, correct order.
//  6. rst asserted after bit 4 of 8
//     -> next cycle vld=0, in_rdy=1.
//     -> A new word 8'h01+8'h01 then serializes cleanly, sum 8'h02.

Source files
------------

// File: rtl/serial_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_pkg                                                      |
// | Purpose  : Shared types and helpers for the serial operand serializer.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package serial_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A length of zero or anything past the operand width means "send the whole word".
    function automatic int len_eff(input int in_len, input int w);
        return ((in_len == 0) || (in_len > w)) ? w : in_len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : piso_shift_reg                                                  |
// | Purpose  : Parallel-in serial-out register, LSB first; load beats shift.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module piso_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_d,
    output logic         o_bit0
);

    logic [W-1:0] r_sh;

    // On the last bit of a word a new word may load in the same edge; the load wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_d;
        end else if (i_shift) begin
            r_sh <= {1'b0, r_sh[W-1:1]};
        end
    end

    assign o_bit0 = r_sh[0];

endmodule
`default_nettype wire

// File: rtl/serial_operand_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_operand_serializer                                       |
// | Purpose  : Serializes operand pairs LSB-first for the serial adder.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module serial_operand_serializer
    import serial_pkg::*;
#(
    parameter  int W  = 8,
    localparam int LW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic [LW-1:0] in_len,
    input  logic          out_en,
    output logic          vld,
    output logic          a,
    output logic          b,
    output logic          last,
    output logic          busy
);

    state_t        r_state;
    logic [LW-1:0] r_cnt;

    logic          w_busy;
    logic          w_accept;
    logic [LW-1:0] w_len_eff;

    assign w_busy    = (r_state == SHIFT);
    assign w_len_eff = LW'(len_eff(int'(in_len), W));

    assign busy   = w_busy;
    assign vld    = w_busy && out_en;
    assign last   = w_busy && (r_cnt == LW'(1));
    // Ready on the final bit lets the next word start with no bubble.
    assign in_rdy = (r_state == IDLE) || (vld && last);

    assign w_accept = in_vld && in_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= SHIFT;
            r_cnt   <= w_len_eff;
        end else if (vld) begin
            r_cnt <= r_cnt - LW'(1);
            if (last) begin
                r_state <= IDLE;
            end
        end
    end

    piso_shift_reg #(
        .W (W)
    ) u_sh_a (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_shift (vld),
        .i_d     (in_a),
        .o_bit0  (a)
    );

    piso_shift_reg #(
        .W (W)
    ) u_sh_b (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_shift (vld),
        .i_d     (in_b),
        .o_bit0  (b)
    );

endmodule
`default_nettype wire

// File: tb/tb_serial_operand_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_serial_operand_serializer                                    |
// | Purpose  : Scoreboard bench for the serializer with a serial adder model.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_serial_operand_serializer;

    localparam int C_W  = 8;
    localparam int C_LW = $clog2(C_W + 1);

    logic            clk;
    logic            rst;
    logic            in_vld;
    logic            in_rdy;
    logic [C_W-1:0]  in_a;
    logic [C_W-1:0]  in_b;
    logic [C_LW-1:0] in_len;
    logic            out_en;
    logic            vld;
    logic            a;
    logic            b;
    logic            last;
    logic            busy;

    serial_operand_serializer #(
        .W (C_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .in_vld (in_vld),
        .in_rdy (in_rdy),
        .in_a   (in_a),
        .in_b   (in_b),
        .in_len (in_len),
        .out_en (out_en),
        .vld    (vld),
        .a      (a),
        .b      (b),
        .last   (last),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic a;
        logic b;
        logic last;
    } bit_t;

    bit_t           q[$];
    logic [C_W-1:0] sum_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_vld    = 0;
    int n_runs   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Consumer side: pops expected bits on every vld and rebuilds the adder sum.
    initial begin
        bit_t           e;
        logic           carry;
        logic           s;
        logic           prev_vld;
        int             idx;
        logic [C_W-1:0] sacc;
        carry = 1'b0; idx = 0; sacc = '0; prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                sum_q.delete();
                carry = 1'b0; idx = 0; sacc = '0; prev_vld = 1'b0;
            end else begin
                if (vld) begin
                    n_vld++;
                    if (!prev_vld) n_runs++;
                    if (q.size() == 0) begin
                        chk("spurious_vld", 32'(vld), 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("bit_a", 32'(a), 32'(e.a));
                        chk("bit_b", 32'(b), 32'(e.b));
                        chk("bit_last", 32'(last), 32'(e.last));
                        s     = a ^ b ^ carry;
                        carry = (a & b) | (a & carry) | (b & carry);
                        sacc[idx] = s;
                        idx++;
                        if (e.last) begin
                            chk("rdy_on_last", 32'(in_rdy), 32'd1);
                            if (sum_q.size() == 0) chk("sum_unexpected", 32'(sacc), 32'hFFFF_FFFF);
                            else chk("sum", 32'(sacc), 32'(sum_q.pop_front()));
                            carry = 1'b0; idx = 0; sacc = '0;
                        end
                    end
                end else if (busy && (q.size() != 0)) begin
                    chk("stall_a", 32'(a), 32'(q[0].a));
                    chk("stall_b", 32'(b), 32'(q[0].b));
                end
                prev_vld = vld;
            end
        end
    end

    task automatic send(input logic [C_W-1:0] av, input logic [C_W-1:0] bv, input logic [C_LW-1:0] len);
        int             le;
        logic           ok;
        logic [C_W-1:0] mask;
        logic [C_W:0]   full;
        le   = ((len == 0) || (int'(len) > C_W)) ? C_W : int'(len);
        mask = (le == C_W) ? {C_W{1'b1}} : C_W'((1 << le) - 1);
        in_a = av; in_b = bv; in_len = len; in_vld = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept", 32'(ok), 32'd1);
        for (int i = 0; i < le; i++) q.push_back('{av[i], bv[i], (i == le - 1)});
        full = {1'b0, av} + {1'b0, bv};
        sum_q.push_back(full[C_W-1:0] & mask);
        @(posedge clk); #1;
        in_vld = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; (i < 200) && (q.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int         v0;
        int         r0;
        logic [3:0] pat;
        rst = 1'b1; in_vld = 1'b0; in_a = '0; in_b = '0; in_len = '0; out_en = 1'b1;

        // Reset held three cycles
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_rdy", 32'(in_rdy), 32'd1);
            chk("rst_vld",    32'(vld),    32'd0);
            chk("rst_last",   32'(last),   32'd0);
            chk("rst_busy",   32'(busy),   32'd0);
            chk("rst_a",      32'(a),      32'd0);
            chk("rst_b",      32'(b),      32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Full word, in_len=0 means all 8 bits
        v0 = n_vld; r0 = n_runs;
        send(8'hA5, 8'h3C, 4'd0);
        wait_drain();
        chk("w1_vld_count", 32'(n_vld - v0), 32'd8);
        chk("w1_runs",      32'(n_runs - r0), 32'd1);

        // Short word
        send(8'hFF, 8'h01, 4'd3);
        wait_drain();
        @(negedge clk);
        chk("len3_idle_vld",  32'(vld),  32'd0);
        chk("len3_idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Oversized length clamps to W, and length 1 marks last on the first bit
        send(8'h81, 8'h7F, 4'd15);
        wait_drain();
        send(8'h01, 8'h01, 4'd1);
        wait_drain();

        // Back-to-back words without a gap
        v0 = n_vld; r0 = n_runs;
        send(8'h0F, 8'h01, 4'd0);
        send(8'h80, 8'h80, 4'd0);
        wait_drain();
        chk("b2b_vld_count", 32'(n_vld - v0), 32'd16);
        chk("b2b_runs",      32'(n_runs - r0), 32'd1);

        // Downstream stalls
        v0 = n_vld;
        pat = 4'b1001;
        send(8'h6B, 8'h5D, 4'd0);
        for (int k = 0; (k < 100) && (q.size() != 0); k++) begin
            out_en = pat[k % 4];
            @(posedge clk); #1;
        end
        out_en = 1'b1;
        chk("stall_drain",     32'(q.size()), 32'd0);
        chk("stall_vld_count", 32'(n_vld - v0), 32'd8);

        // Reset after four bits of a word
        send(8'hC3, 8'h11, 4'd0);
        for (int k = 0; (k < 100) && (q.size() > 4); k++) begin
            @(posedge clk); #1;
        end
        chk("midrst_progress", 32'(q.size()), 32'd4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_vld",    32'(vld),    32'd0);
        chk("midrst_in_rdy", 32'(in_rdy), 32'd1);
        chk("midrst_last",   32'(last),   32'd0);
        chk("midrst_busy",   32'(busy),   32'd0);
        @(posedge clk); #1;
        v0 = n_vld;
        send(8'h01, 8'h01, 4'd0);
        wait_drain();
        chk("post_rst_vld_count", 32'(n_vld - v0), 32'd8);
        chk("sum_queue_empty",    32'(sum_q.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
